// File: rtl/kan_pkg.sv
// Shared defaults and FSM state type for the KAN input framer.
// Optional clamp feature is selected with macro KAN_INPUT_SAT_EN.
package kan_pkg;

    localparam int unsigned KAN_DATA_W      = 16;
    localparam int unsigned KAN_IN_FEATURES = 2;
    localparam int unsigned KAN_HOLD_CYCLES = 4;
    localparam int unsigned KAN_HOLD_W      = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        CAPTURE = 2'd2
    } kan_state_e;

endpackage

// File: rtl/kan_input_clamp.sv
// Unsigned clamp of one feature word to [SAT_MIN, SAT_MAX]; purely combinational.
module kan_input_clamp
    import kan_pkg::*;
#(
    parameter int unsigned DATA_W  = KAN_DATA_W,
    parameter int unsigned SAT_MIN = 0,
    parameter int unsigned SAT_MAX = 255
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_c,
    output logic              clamped_c
);

    localparam logic [DATA_W-1:0] LO = DATA_W'(SAT_MIN);
    localparam logic [DATA_W-1:0] HI = DATA_W'(SAT_MAX);

    logic below_c;
    logic above_c;

    // A bound at the edge of the word range can never be crossed, so skip its compare
    if (SAT_MIN > 0) begin : g_lo
        assign below_c = (din < LO);
    end else begin : g_no_lo
        assign below_c = 1'b0;
    end

    if (SAT_MAX < ((64'd1 << DATA_W) - 64'd1)) begin : g_hi
        assign above_c = (din > HI);
    end else begin : g_no_hi
        assign above_c = 1'b0;
    end

    always_comb begin
        dout_c    = din;
        clamped_c = 1'b0;
        if (below_c) begin
            dout_c    = LO;
            clamped_c = 1'b1;
        end else if (above_c) begin
            dout_c    = HI;
            clamped_c = 1'b1;
        end
    end

endmodule

// File: rtl/kan_input_framer.sv
// Collects a serial feature stream into a parallel vector, holds it for the KAN core, then strobes capture.
// Define KAN_INPUT_SAT_EN to clamp incoming words and report clamping on sat_flag.
module kan_input_framer
    import kan_pkg::*;
#(
    parameter int unsigned IN_FEATURES = KAN_IN_FEATURES,
    parameter int unsigned DATA_W      = KAN_DATA_W,
    parameter int unsigned HOLD_CYCLES = KAN_HOLD_CYCLES,
    parameter int unsigned SAT_MIN     = 0,
    parameter int unsigned SAT_MAX     = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [IN_FEATURES*DATA_W-1:0] vec_data,
    output logic                          capture,
    output logic [15:0]                   frame_count,
    output logic                          sat_flag
);

    localparam int unsigned IDX_W  = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
    localparam int unsigned HOLD_W = KAN_HOLD_W;
    localparam int unsigned VEC_W  = IN_FEATURES * DATA_W;

    if (IN_FEATURES < 1 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || SAT_MAX < SAT_MIN) begin : g_bad_cfg
        $error("kan_input_framer: invalid parameter set");
    end

    kan_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [DATA_W-1:0]  shadow_q [IN_FEATURES];
    logic               sat_acc_q;

    logic [DATA_W-1:0]  word_c;
    logic               clamped_c;
    logic               accept_c;
    logic               last_c;
    logic               capture_d;
    logic [VEC_W-1:0]   vec_next_c;

`ifdef KAN_INPUT_SAT_EN
    kan_input_clamp #(
        .DATA_W  (DATA_W),
        .SAT_MIN (SAT_MIN),
        .SAT_MAX (SAT_MAX)
    ) u_clamp (
        .din       (s_data),
        .dout_c    (word_c),
        .clamped_c (clamped_c)
    );
`else
    assign word_c    = s_data;
    assign clamped_c = 1'b0;
`endif

    // Next-state and strobe decode
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        accept_c  = 1'b0;
        capture_d = 1'b0;
        last_c    = (idx_q == IDX_W'(IN_FEATURES - 1));
        case (state_q)
            COLLECT: begin
                s_ready  = !reset;
                accept_c = s_valid && !flush;
                if (accept_c && last_c) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                capture_d = 1'b1;
                state_d   = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Completed vector: shadow slots plus the word arriving in the last slot
    always_comb begin
        vec_next_c = '0;
        for (int unsigned i = 0; i < IN_FEATURES; i++) begin
            vec_next_c[i*DATA_W +: DATA_W] = shadow_q[i];
        end
        vec_next_c[(IN_FEATURES-1)*DATA_W +: DATA_W] = word_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            for (int unsigned i = 0; i < IN_FEATURES; i++) begin
                shadow_q[i] <= '0;
            end
            sat_acc_q   <= 1'b0;
            vec_data    <= '0;
            capture     <= 1'b0;
            frame_count <= '0;
            sat_flag    <= 1'b0;
        end else begin
            state_q <= state_d;
            capture <= capture_d;
            if (capture_d) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state_q)
                COLLECT: begin
                    if (flush) begin
                        idx_q     <= '0;
                        sat_acc_q <= 1'b0;
                        for (int unsigned i = 0; i < IN_FEATURES; i++) begin
                            shadow_q[i] <= '0;
                        end
                    end else if (accept_c) begin
                        shadow_q[idx_q] <= word_c;
                        if (last_c) begin
                            vec_data   <= vec_next_c;
                            sat_flag   <= sat_acc_q | clamped_c;
                            sat_acc_q  <= 1'b0;
                            idx_q      <= '0;
                            hold_cnt_q <= HOLD_W'(HOLD_CYCLES - 1);
                        end else begin
                            sat_acc_q  <= sat_acc_q | clamped_c;
                            idx_q      <= idx_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kan_input_framer.sv
// Self-checking bench for kan_input_framer: directed scenarios plus random traffic against a frame-level model.
module tb_kan_input_framer;

    localparam int unsigned IN_F = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned HOLD = 4;
    localparam int unsigned SMIN = 0;
    localparam int unsigned SMAX = 255;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [IN_F*DW-1:0]   vec_data;
    logic                 capture;
    logic [15:0]          frame_count;
    logic                 sat_flag;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0]        m_words[$];
    int                   m_busy = 0;
    logic [IN_F*DW-1:0]   m_vec = '0;
    logic                 m_cap = 1'b0;
    logic [15:0]          m_fc = '0;
    logic                 m_sat = 1'b0;
    logic                 m_acc = 1'b0;
    logic                 m_rst = 1'b0;

    kan_input_framer #(
        .IN_FEATURES (IN_F),
        .DATA_W      (DW),
        .HOLD_CYCLES (HOLD),
        .SAT_MIN     (SMIN),
        .SAT_MAX     (SMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .vec_data    (vec_data),
        .capture     (capture),
        .frame_count (frame_count),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_clamp(input logic [DW-1:0] x);
`ifdef KAN_INPUT_SAT_EN
        if (32'(x) < SMIN) return DW'(SMIN);
        if (32'(x) > SMAX) return DW'(SMAX);
`endif
        return x;
    endfunction

    // One clock of the frame-level behaviour: collect words, then stay busy HOLD+1 cycles
    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit fl, input bit rst);
        logic [DW-1:0] c;
        if (rst) begin
            m_words.delete();
            m_busy = 0;
            m_vec  = '0;
            m_cap  = 1'b0;
            m_fc   = '0;
            m_sat  = 1'b0;
            m_acc  = 1'b0;
        end else begin
            m_cap = 1'b0;
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_cap = 1'b1;
                    m_fc  = m_fc + 16'd1;
                end
            end else if (fl) begin
                m_words.delete();
                m_acc = 1'b0;
            end else if (v) begin
                c = model_clamp(d);
                m_acc = m_acc | (c != d);
                m_words.push_back(c);
                if (m_words.size() == IN_F) begin
                    for (int i = 0; i < int'(IN_F); i++) m_vec[i*DW +: DW] = m_words[i];
                    m_sat = m_acc;
                    m_acc = 1'b0;
                    m_words.delete();
                    m_busy = HOLD + 1;
                end
            end
        end
        m_rst = rst;
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit fl, input bit rst);
        s_valid = v;
        s_data  = d;
        flush   = fl;
        reset   = rst;
        @(posedge clk);
        model_edge(v, d, fl, rst);
        #1;
        check("vec_data", 64'(vec_data), 64'(m_vec));
        check("capture", 64'(capture), 64'(m_cap));
        check("frame_count", 64'(frame_count), 64'(m_fc));
        check("sat_flag", 64'(sat_flag), 64'(m_sat));
        check("s_ready", 64'(s_ready), 64'((m_busy == 0) && !m_rst));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [IN_F*DW-1:0] exp_vec;

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        flush   = 1'b0;
        reset   = 1'b1;

        // Reset state
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'd9, 1'b0, 1'b1);
        check("rst_vec", 64'(vec_data), 64'd0);
        check("rst_fc", 64'(frame_count), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_capture", 64'(capture), 64'd0);

        // Basic frame and capture timing
        step(1'b1, 16'd50, 1'b0, 1'b0);
        step(1'b1, 16'd30, 1'b0, 1'b0);
        exp_vec = {16'd30, 16'd50};
        check("basic_vec", 64'(vec_data), 64'(exp_vec));
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 16'd77, 1'b0, 1'b0);
            check("basic_cap_timing", 64'(capture), 64'(k == 5));
        end
        check("basic_fc", 64'(frame_count), 64'd1);
        idle(1);

        // Backpressure: 150 waits through hold and capture, then leads the next frame
        step(1'b1, 16'd100, 1'b0, 1'b0);
        step(1'b1, 16'd200, 1'b0, 1'b0);
        exp_vec = {16'd200, 16'd100};
        check("bp_vec1", 64'(vec_data), 64'(exp_vec));
        for (int k = 0; k < 6; k++) step(1'b1, 16'd150, 1'b0, 1'b0);
        step(1'b1, 16'd40, 1'b0, 1'b0);
        exp_vec = {16'd40, 16'd150};
        check("bp_vec2", 64'(vec_data), 64'(exp_vec));
        idle(6);

        // Flush discards a partial frame, and flush beats a simultaneous transfer
        step(1'b1, 16'd75, 1'b0, 1'b0);
        step(1'b1, 16'd99, 1'b1, 1'b0);
        step(1'b1, 16'd175, 1'b0, 1'b0);
        step(1'b1, 16'd225, 1'b0, 1'b0);
        exp_vec = {16'd225, 16'd175};
        check("flush_vec", 64'(vec_data), 64'(exp_vec));
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // Saturation
        step(1'b1, 16'd300, 1'b0, 1'b0);
        step(1'b1, 16'd125, 1'b0, 1'b0);
`ifdef KAN_INPUT_SAT_EN
        exp_vec = {16'd125, 16'd255};
        check("sat_vec", 64'(vec_data), 64'(exp_vec));
        check("sat_flag_set", 64'(sat_flag), 64'd1);
`else
        exp_vec = {16'd125, 16'd300};
        check("sat_vec", 64'(vec_data), 64'(exp_vec));
        check("sat_flag_off", 64'(sat_flag), 64'd0);
`endif
        idle(6);
        step(1'b1, 16'd10, 1'b0, 1'b0);
        step(1'b1, 16'd20, 1'b0, 1'b0);
        check("sat_flag_clear", 64'(sat_flag), 64'd0);

        // Reset two cycles into hold aborts the frame
        idle(2);
        step(1'b1, 16'd1, 1'b0, 1'b1);
        check("rhold_vec", 64'(vec_data), 64'd0);
        check("rhold_fc", 64'(frame_count), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("rhold_ready", 64'(s_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            check("rhold_no_cap", 64'(capture), 64'd0);
        end

        // Frame counter wrap from 0xFFFF
        dut.frame_count = 16'hFFFF;
        m_fc = 16'hFFFF;
        step(1'b1, 16'd3, 1'b0, 1'b0);
        step(1'b1, 16'd4, 1'b0, 1'b0);
        idle(5);
        check("wrap_fc", 64'(frame_count), 64'd0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 3) != 0),
                 DW'($urandom_range(0, 400)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
